bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) feeding the seven-segment digit decoders. It takes a binary value from the datapath, for example a register, PC or counter being displayed. It produces one 4-bit BCD code per display digit, and each code drives one decoder instance. Codes 4'hA–4'hF are treated downstream as a blank digit.

## Interface
- `W`, default 16: width of the binary input.
- `DIGITS`, default 5: number of BCD digits produced. Must be ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  **reset is synchronous and active-high**. There is one clock domain.
- `in_valid`  in  1  `in_bin` holds a value to convert.
- `in_ready`  out  1  converter can accept a value. Combinational from state.
- `in_bin`  in  W  unsigned binary value.
- `out_valid`  out  1  one-cycle pulse: `out_bcd` and `out_ovf` were just updated.
- `out_bcd`  out  4*DIGITS  digit k is `[4k+3:4k]`. Digit 0 is the least significant.
- `out_ovf`  out  1  last value exceeded 10^DIGITS − 1.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: capture `in_bin` into a shift register, clear the BCD scratch register and overflow flag, load bit counter = W, go to SHIFT.
- **SHIFT:** each cycle does three things.
  - Every scratch digit ≥ 5 gets +3.
  - The whole {scratch, binary} register shifts left one bit.
  - The counter decrements. When the counter reaches 1 on this cycle, go to DONE.
- **Overflow:** any 1 shifted out of the top scratch digit sets the sticky overflow flag.
- **DONE** (one cycle):
  - Register the scratch into `out_bcd` and the flag into `out_ovf`.
  - Assert `out_valid`.
  - Return to IDLE.
- **Overflow result:** `out_bcd` is all digits 4'hF (fully blank), and `out_ovf` = 1.
- **Output stability:** `out_bcd` and `out_ovf` hold their value between DONE cycles, so they stay stable for the static display.
- **Ignored input:** `in_valid` is ignored while `in_ready` = 0. There is no queueing.
- **Width arithmetic:** digit add-3 is 4-bit. The scratch register is exactly 4*DIGITS bits, with no extra guard bits.
- **Reset values:** state IDLE, `out_bcd` = all 4'h0 (but see Configuration), `out_ovf` = 0, `out_valid` = 0. Counter and scratch are cleared.
- **Reset mid-SHIFT or in DONE:** abort. No `out_valid` pulse, and outputs take their reset values.

## Timing
- **Latency:** accept edge → W SHIFT cycles → DONE cycle. `out_valid` is high in the (W+1)th cycle after the accept edge.
- **Throughput:** with `in_valid` held high, accepts occur every W+2 cycles. The next accept happens in the IDLE cycle following DONE.
- **`in_ready`:** low during SHIFT and DONE. High in the cycle after reset deasserts.
- **`out_valid`:** never high for two consecutive cycles.

## Configuration
- **`BIN2BCD_BLANK_EN` defined:** leading-zero blanking is applied when DONE registers `out_bcd`.
  - Every zero digit above the most significant non-zero digit is replaced by 4'hF.
  - Digit 0 is never blanked.
  - The reset value becomes all 4'hF except digit 0 = 4'h0.
- **Not defined:** all digits are output as raw BCD, leading zeros included.
- Overflow behaviour is identical in both cases.

## Structure
- **Shared package `dig_pkg`:**
  - Constants `DIG_W = 4` and `DIG_BLANK = 4'hF`.
  - State encoding `IDLE`/`SHIFT`/`DONE` as a 2-bit typedef.
  - Constant `ADJ_THRESH = 5`.
- **Sub-module `bcd_adj3`:** a combinational per-digit "if ≥ 5 add 3". Instantiated DIGITS times via generate.
- **Top level:** the FSM, counter (width ⌈log2(W+1)⌉), shift registers and output blanking/overflow mux.

## Test plan
- **Zero, defaults:** `in_bin` = 0.
  - Blanking off: `out_valid` at cycle 17, `out_bcd` = 20'h00000.
  - Blanking on: `out_bcd` = 20'hFFFF0.
- **Maximum, defaults:** `in_bin` = 65535 → `out_bcd` = 20'h65535, `out_ovf` = 0, regardless of blanking.
- **Leading-zero blanking:** `in_bin` = 1234 with `BIN2BCD_BLANK_EN` → `out_bcd` = 20'hF1234. Without it → 20'h01234.
- **Overflow:** `DIGITS` = 4, `in_bin` = 10000 → `out_ovf` = 1, `out_bcd` = 16'hFFFF. A following `in_bin` = 9999 → 16'h9999, `out_ovf` = 0.
- **Back-to-back:** hold `in_valid` high with values 7 then 42.
  - Accepts are 18 cycles apart.
  - `out_bcd` holds the 7 result (digit 0 = 4'h7) until the second `out_valid`, then shows 42.
  - `in_bin` changes while `in_ready` = 0 are ignored.
- **Reset mid-operation:** assert `rst` for one cycle at SHIFT cycle 8 of `in_bin` = 500.
  - No `out_valid` pulse.
  - `out_bcd` takes its reset value.
  - `in_ready` = 1 on the next cycle.
  - A fresh conversion of 500 gives 20'h00500.

Source files
------------

// File: rtl/dig_pkg.sv
// -----------------------------------------------------------------------------
// dig_pkg
// Constants and types shared by the BCD conversion datapath and the
// seven-segment digit path.
//   DIG_W       width of one BCD digit
//   DIG_BLANK   code shown as a blank digit by the downstream decoders
//   ADJ_THRESH  digit value at and above which shift-and-add-3 adds 3
//   state_e     converter FSM state encoding
// -----------------------------------------------------------------------------
package dig_pkg;

    localparam int         DIG_W      = 4;
    localparam logic [3:0] DIG_BLANK  = 4'hF;
    localparam logic [3:0] ADJ_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_adj3.sv
// -----------------------------------------------------------------------------
// bcd_adj3
// Combinational per-digit correction for shift-and-add-3: a digit of 5 or
// more gets +3, so that the following left shift carries into the next digit.
// Ports:
//   dig_i  in   DIG_W  BCD digit before correction
//   dig_o  out  DIG_W  corrected digit (4-bit arithmetic, max 9+3 = 12 fits)
// -----------------------------------------------------------------------------
module bcd_adj3
    import dig_pkg::*;
(
    input  logic [DIG_W-1:0] dig_i,
    output logic [DIG_W-1:0] dig_o
);

    assign dig_o = (dig_i >= ADJ_THRESH) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving the seven-segment digit decoders. One value is converted at a time;
// the result registers hold between conversions for a static display.
//
// Optional feature: define BIN2BCD_BLANK_EN to replace leading zero digits
// (never digit 0) by DIG_BLANK when a result is registered.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          in_bin holds a value to convert
//   in_ready   out  1          converter idle, a value can be accepted
//   in_bin     in   W          unsigned binary value
//   out_valid  out  1          one-cycle pulse, out_bcd/out_ovf just updated
//   out_bcd    out  4*DIGITS   digit k at [4k+3:4k], digit 0 least significant
//   out_ovf    out  1          last value exceeded 10^DIGITS - 1
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import dig_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_bin,
    output logic                    out_valid,
    output logic [DIG_W*DIGITS-1:0] out_bcd,
    output logic                    out_ovf
);

    localparam int BCD_W = DIG_W * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

`ifdef BIN2BCD_BLANK_EN
    localparam logic [BCD_W-1:0] RST_BCD = {DIGITS{DIG_BLANK}} ^ BCD_W'(DIG_BLANK);
`else
    localparam logic [BCD_W-1:0] RST_BCD = '0;
`endif

    state_e             state_q, state_d;
    logic [W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               ovf_out_q, ovf_out_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;
    logic [W-1:0]       bin_shift;
    logic               ovf_next;

    // Leading-zero blanking applied to a finished BCD result.
    function automatic logic [BCD_W-1:0] fmt_digits(input logic [BCD_W-1:0] raw);
        logic [BCD_W-1:0] res;
        res = raw;
`ifdef BIN2BCD_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (lead && (raw[k*DIG_W +: DIG_W] == 4'h0)) begin
                    res[k*DIG_W +: DIG_W] = DIG_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
        return res;
    endfunction

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_adj3 u_adj (
                .dig_i (scr_q[g*DIG_W +: DIG_W]),
                .dig_o (scr_adj[g*DIG_W +: DIG_W])
            );
        end
    endgenerate

    // The bit leaving the top digit has no home in the scratch register;
    // a 1 there means the value does not fit in DIGITS digits.
    assign {scr_shift, bin_shift} = {scr_adj[BCD_W-2:0], bin_q, 1'b0};
    assign ovf_next               = ovf_q | scr_adj[BCD_W-1];

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        ovf_out_d = ovf_out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = bin_shift;
                scr_d = scr_shift;
                ovf_d = ovf_next;
                cnt_d = cnt_q - CNT_W'(1);
                // Result registers load with the final shift so they are
                // already updated during the DONE cycle that flags them.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    ovf_out_d = ovf_next;
                    bcd_out_d = ovf_next ? {DIGITS{DIG_BLANK}} : fmt_digits(scr_shift);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            scr_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_out_q <= RST_BCD;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scr_q     <= scr_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    // Binary shift register carries data only; its contents are irrelevant
    // until the next accept overwrites it.
    always_ff @(posedge clk) begin
        bin_q <= bin_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_out_q;
    assign out_ovf   = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv5 = 1'b0;
    logic [15:0] ib5 = '0;
    logic        rdy5, ov5, ovf5;
    logic [19:0] bcd5;

    logic        iv4 = 1'b0;
    logic [15:0] ib4 = '0;
    logic        rdy4, ov4, ovf4;
    logic [15:0] bcd4;

    logic        sel4 = 1'b0;
    logic        rdy_s, ov_s, ovf_s;
    logic [19:0] bcd_s;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [19:0] RST5  = 20'hFFFF0;
    localparam logic [19:0] RST4  = 20'h0FFF0;
    localparam logic [19:0] E0    = 20'hFFFF0;
    localparam logic [19:0] E1234 = 20'hF1234;
    localparam logic [19:0] E7    = 20'hFFFF7;
    localparam logic [19:0] E42   = 20'hFFF42;
    localparam logic [19:0] E500  = 20'hFF500;
`else
    localparam logic [19:0] RST5  = 20'h00000;
    localparam logic [19:0] RST4  = 20'h00000;
    localparam logic [19:0] E0    = 20'h00000;
    localparam logic [19:0] E1234 = 20'h01234;
    localparam logic [19:0] E7    = 20'h00007;
    localparam logic [19:0] E42   = 20'h00042;
    localparam logic [19:0] E500  = 20'h00500;
`endif

    always #5 clk = ~clk;

    bin2bcd_seq #(.W(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv5),
        .in_ready  (rdy5),
        .in_bin    (ib5),
        .out_valid (ov5),
        .out_bcd   (bcd5),
        .out_ovf   (ovf5)
    );

    bin2bcd_seq #(.W(16), .DIGITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (rdy4),
        .in_bin    (ib4),
        .out_valid (ov4),
        .out_bcd   (bcd4),
        .out_ovf   (ovf4)
    );

    assign rdy_s = sel4 ? rdy4 : rdy5;
    assign ov_s  = sel4 ? ov4 : ov5;
    assign ovf_s = sel4 ? ovf4 : ovf5;
    assign bcd_s = sel4 ? {4'h0, bcd4} : bcd5;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the out_valid cycle.
    task automatic convert(input string tag, input logic [15:0] val,
                           input logic [19:0] exp_bcd, input logic exp_ovf);
        int  n;
        bit  got;
        n = 0;
        while (!rdy_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_s) check_val({tag, "_ready_timeout"}, 32'd0, 32'd1);
        if (sel4) begin iv4 = 1'b1; ib4 = val; end
        else      begin iv5 = 1'b1; ib5 = val; end
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0; iv5 = 1'b0;
        ib4 = 16'hBEEF; ib5 = 16'hBEEF;
        n   = 1;
        got = 1'b0;
        while (n < 40) begin
            if (ov_s) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check_val({tag, "_latency"}, got ? 32'(n) : 32'd0, 32'd17);
        check_val({tag, "_bcd"}, 32'(bcd_s), 32'(exp_bcd));
        check_val({tag, "_ovf"}, 32'(ovf_s), 32'(exp_ovf));
        @(negedge clk);
        check_val({tag, "_pulse_width"}, 32'(ov_s), 32'd0);
    endtask

    initial begin
        int n, n2, pulses;
        bit got;

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_ready", 32'(rdy5), 32'd1);
        check_val("rst_valid", 32'(ov5), 32'd0);
        check_val("rst_bcd5", 32'(bcd5), 32'(RST5));
        check_val("rst_bcd4", 32'(bcd4), 32'(RST4));
        check_val("rst_ovf", 32'(ovf5), 32'd0);
        @(negedge clk);

        // Single conversions, five digits
        sel4 = 1'b0;
        convert("zero", 16'd0, E0, 1'b0);
        convert("max", 16'd65535, 20'h65535, 1'b0);
        convert("v1234", 16'd1234, E1234, 1'b0);

        // Overflow then recovery, four digits
        sel4 = 1'b1;
        convert("ovf10000", 16'd10000, 20'h0FFFF, 1'b1);
        convert("v9999", 16'd9999, 20'h09999, 1'b0);
        sel4 = 1'b0;

        // Back-to-back with in_valid held high
        iv5 = 1'b1;
        ib5 = 16'd7;
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            if (n == 0) ib5 = 16'd99;
            if (ov5) begin
                check_val("b2b_first_bcd", 32'(bcd5), 32'(E7));
                ib5 = 16'd42;
            end
            if (rdy5) begin
                @(posedge clk);
                n++;
                got = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        check_val("b2b_accept_gap", got ? 32'(n) : 32'd0, 32'd18);
        n2  = 0;
        got = 1'b0;
        while (n2 < 40) begin
            @(negedge clk);
            n2++;
            if (n2 == 8) check_val("b2b_hold", 32'(bcd5), 32'(E7));
            if (ov5) begin
                iv5 = 1'b0;
                got = 1'b1;
                break;
            end
        end
        check_val("b2b_second_latency", got ? 32'(n2) : 32'd0, 32'd17);
        check_val("b2b_second_bcd", 32'(bcd5), 32'(E42));
        @(negedge clk);

        // Reset during SHIFT
        iv5 = 1'b1;
        ib5 = 16'd500;
        @(posedge clk);
        @(negedge clk);
        iv5 = 1'b0;
        n   = 1;
        while (n < 8) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_bcd", 32'(bcd5), 32'(RST5));
        check_val("mid_rst_ready", 32'(rdy5), 32'd1);
        check_val("mid_rst_ovf", 32'(ovf5), 32'd0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (ov5) pulses++;
            @(negedge clk);
        end
        check_val("mid_rst_no_pulse", 32'(pulses), 32'd0);
        convert("v500", 16'd500, E500, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
